// File: rtl/flag_branch_unit.sv
// Flag register and conditional-branch resolver between EX and fetch.
// Define FLAG_FWD_EN to resolve flag hazards by forwarding instead of stalling.
module flag_branch_unit #(
   parameter int DW  = 16,
   parameter int CCW = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           stall,
   input  logic           flush,
   input  logic           alu_valid,
   input  logic [3:0]     alu_opcode,
   input  logic [2:0]     alu_flags,
   input  logic           br_valid,
   input  logic [CCW-1:0] br_cond,
   input  logic [DW-1:0]  br_target,
   input  logic [DW-1:0]  pc_plus2,
   output logic [2:0]     flags_q,
   output logic           hazard_stall,
   output logic           br_done,
   output logic           br_taken,
   output logic [DW-1:0]  next_pc
);

   typedef enum logic {
      S_IDLE,
      S_WAIT_FLAGS
   } state_t;

   localparam logic [CCW-1:0] CC_NE = CCW'(0);
   localparam logic [CCW-1:0] CC_EQ = CCW'(1);
   localparam logic [CCW-1:0] CC_GT = CCW'(2);
   localparam logic [CCW-1:0] CC_LT = CCW'(3);
   localparam logic [CCW-1:0] CC_GE = CCW'(4);
   localparam logic [CCW-1:0] CC_LE = CCW'(5);
   localparam logic [CCW-1:0] CC_OV = CCW'(6);

   state_t          r_state;
   logic [2:0]      r_flags;
   logic            r_br_done;
   logic            r_br_taken;
   logic [DW-1:0]   r_next_pc;
   logic [CCW-1:0]  r_cap_cond;
   logic [DW-1:0]   r_cap_target;
   logic [DW-1:0]   r_cap_pc;

   logic            w_writes_z;
   logic            w_writes_vn;
   logic [2:0]      w_flags_next;
   logic            w_hazard;
   logic            w_defer;
   logic [2:0]      w_eval_flags;
   logic [CCW-1:0]  w_eval_cond;
   logic [DW-1:0]   w_eval_target;
   logic [DW-1:0]   w_eval_pc;
   logic            w_taken;

   // Flags are {Z, V, N}; GE reduces to Z | !N.
   function automatic logic cond_met(input logic [CCW-1:0] cond, input logic [2:0] f);
      case (cond)
         CC_NE:   return !f[2];
         CC_EQ:   return f[2];
         CC_GT:   return !f[2] && !f[0];
         CC_LT:   return f[0];
         CC_GE:   return f[2] || (!f[2] && !f[0]);
         CC_LE:   return f[0] || f[2];
         CC_OV:   return f[1];
         default: return 1'b1;
      endcase
   endfunction

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      w_writes_z  = 1'b0;
      w_writes_vn = 1'b0;
      case (alu_opcode)
         4'b0000, 4'b0001: begin
            w_writes_z  = 1'b1;
            w_writes_vn = 1'b1;
         end
         4'b0010, 4'b0100, 4'b0101, 4'b0110: w_writes_z = 1'b1;
         default: ;
      endcase

      w_flags_next = r_flags;
      if (alu_valid) begin
         if (w_writes_z)  w_flags_next[2]   = alu_flags[2];
         if (w_writes_vn) w_flags_next[1:0] = alu_flags[1:0];
      end

      // A flushed branch never waits, so it cannot raise a hazard.
      w_hazard = (r_state == S_IDLE) && br_valid && alu_valid && w_writes_z && !flush;
`ifdef FLAG_FWD_EN
      w_defer      = 1'b0;
      w_eval_flags = w_hazard ? w_flags_next : r_flags;
`else
      w_defer      = w_hazard;
      w_eval_flags = r_flags;
`endif

      if (r_state == S_WAIT_FLAGS) begin
         w_eval_cond   = r_cap_cond;
         w_eval_target = r_cap_target;
         w_eval_pc     = r_cap_pc;
      end else begin
         w_eval_cond   = br_cond;
         w_eval_target = br_target;
         w_eval_pc     = pc_plus2;
      end
      w_taken = cond_met(w_eval_cond, w_eval_flags);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_flags      <= '0;
         r_br_done    <= 1'b0;
         r_br_taken   <= 1'b0;
         r_next_pc    <= '0;
         r_cap_cond   <= '0;
         r_cap_target <= '0;
         r_cap_pc     <= '0;
      end else if (!stall) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_flags   <= w_flags_next;
         r_br_done <= 1'b0;
         if (flush) begin
            r_state      <= S_IDLE;
            r_cap_cond   <= '0;
            r_cap_target <= '0;
            r_cap_pc     <= '0;
         end else if (r_state == S_WAIT_FLAGS) begin
            r_br_done  <= 1'b1;
            r_br_taken <= w_taken;
            r_next_pc  <= w_taken ? w_eval_target : w_eval_pc;
            r_state    <= S_IDLE;
         end else if (br_valid && w_defer) begin
            r_cap_cond   <= br_cond;
            r_cap_target <= br_target;
            r_cap_pc     <= pc_plus2;
            r_state      <= S_WAIT_FLAGS;
         end else if (br_valid) begin
            r_br_done  <= 1'b1;
            r_br_taken <= w_taken;
            r_next_pc  <= w_taken ? w_eval_target : w_eval_pc;
         end
      end
   end

   assign flags_q      = r_flags;
   assign hazard_stall = w_defer;
   assign br_done      = r_br_done;
   assign br_taken     = r_br_taken;
   assign next_pc      = r_next_pc;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: vector table plus hand-written
// hazard/stall/flush sequences, compared through an expected-result queue.
module tb_flag_branch_unit;

`ifdef FLAG_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, alu_valid, br_valid;
   logic [3:0]  alu_opcode;
   logic [2:0]  alu_flags, br_cond;
   logic [15:0] br_target, pc_plus2;
   logic [2:0]  flags_q;
   logic        hazard_stall, br_done, br_taken;
   logic [15:0] next_pc;

   int n_total = 0;
   int n_pass  = 0;
   logic [31:0] sb_q[$];

   flag_branch_unit #(.DW(16), .CCW(3)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .alu_valid(alu_valid), .alu_opcode(alu_opcode), .alu_flags(alu_flags),
      .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
      .pc_plus2(pc_plus2), .flags_q(flags_q), .hazard_stall(hazard_stall),
      .br_done(br_done), .br_taken(br_taken), .next_pc(next_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [3:0]  op;
      logic [2:0]  fl;
      logic        bv;
      logic [2:0]  cc;
      logic [15:0] tg;
      logic [15:0] pc;
      logic [2:0]  e_flags;
      logic        e_done;
      logic        e_taken;
      logic [15:0] e_pc;
   } vec_t;

   vec_t vecs[23];

   function automatic vec_t mk(input logic av, input logic [3:0] op, input logic [2:0] fl,
                               input logic bv, input logic [2:0] cc, input logic [15:0] tg,
                               input logic [15:0] pc, input logic [2:0] ef, input logic ed,
                               input logic et, input logic [15:0] ep);
      vec_t v;
      v.av = av; v.op = op; v.fl = fl; v.bv = bv; v.cc = cc; v.tg = tg; v.pc = pc;
      v.e_flags = ef; v.e_done = ed; v.e_taken = et; v.e_pc = ep;
      return v;
   endfunction

   function automatic logic [31:0] pk(input logic [2:0] f, input logic d, input logic t,
                                      input logic [15:0] p);
      return {11'd0, f, d, t, p};
   endfunction

   function automatic logic [31:0] outs();
      return pk(flags_q, br_done, br_taken, next_pc);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got flags=%b done=%b taken=%b pc=%h, expected flags=%b done=%b taken=%b pc=%h",
                  name, act[20:18], act[17], act[16], act[15:0],
                  exp[20:18], exp[17], exp[16], exp[15:0]);
      else
         n_pass++;
   endtask

   task automatic drive(input logic av, input logic [3:0] op, input logic [2:0] fl,
                        input logic bv, input logic [2:0] cc, input logic [15:0] tg,
                        input logic [15:0] pc);
      alu_valid = av; alu_opcode = op; alu_flags = fl;
      br_valid = bv; br_cond = cc; br_target = tg; pc_plus2 = pc;
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, 3'b000, 1'b0, 3'b000, 16'h0, 16'h0);
   endtask

   // Expected outputs are queued when stimulus is driven, compared after the edge.
   task automatic step(input string name, input logic [31:0] exp);
      logic [31:0] e;
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check(name, outs(), e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(1, 4'b0000, 3'b110, 0, 3'd0, 16'h0000, 16'h0000, 3'b110, 0, 0, 16'h0000);
      vecs[1]  = mk(1, 4'b0010, 3'b001, 0, 3'd0, 16'h0000, 16'h0000, 3'b010, 0, 0, 16'h0000);
      vecs[2]  = mk(1, 4'b0001, 3'b000, 0, 3'd0, 16'h0000, 16'h0000, 3'b000, 0, 0, 16'h0000);
      vecs[3]  = mk(1, 4'b0011, 3'b111, 0, 3'd0, 16'h0000, 16'h0000, 3'b000, 0, 0, 16'h0000);
      vecs[4]  = mk(1, 4'b0111, 3'b111, 0, 3'd0, 16'h0000, 16'h0000, 3'b000, 0, 0, 16'h0000);
      vecs[5]  = mk(1, 4'b1010, 3'b111, 0, 3'd0, 16'h0000, 16'h0000, 3'b000, 0, 0, 16'h0000);
      vecs[6]  = mk(1, 4'b0100, 3'b101, 0, 3'd0, 16'h0000, 16'h0000, 3'b100, 0, 0, 16'h0000);
      vecs[7]  = mk(0, 4'b0000, 3'b000, 1, 3'd1, 16'h0040, 16'h0012, 3'b100, 1, 1, 16'h0040);
      vecs[8]  = mk(0, 4'b0000, 3'b000, 1, 3'd0, 16'h0040, 16'h0012, 3'b100, 1, 0, 16'h0012);
      vecs[9]  = mk(0, 4'b0000, 3'b000, 0, 3'd0, 16'h0000, 16'h0000, 3'b100, 0, 0, 16'h0012);
      vecs[10] = mk(1, 4'b0001, 3'b001, 0, 3'd0, 16'h0000, 16'h0000, 3'b001, 0, 0, 16'h0012);
      vecs[11] = mk(0, 4'b0000, 3'b000, 1, 3'd3, 16'h1234, 16'h0100, 3'b001, 1, 1, 16'h1234);
      vecs[12] = mk(0, 4'b0000, 3'b000, 1, 3'd4, 16'h1234, 16'h0100, 3'b001, 1, 0, 16'h0100);
      vecs[13] = mk(0, 4'b0000, 3'b000, 1, 3'd5, 16'h1234, 16'h0100, 3'b001, 1, 1, 16'h1234);
      vecs[14] = mk(0, 4'b0000, 3'b000, 1, 3'd6, 16'h1234, 16'h0100, 3'b001, 1, 0, 16'h0100);
      vecs[15] = mk(1, 4'b0000, 3'b000, 0, 3'd0, 16'h0000, 16'h0000, 3'b000, 0, 0, 16'h0100);
      vecs[16] = mk(0, 4'b0000, 3'b000, 1, 3'd2, 16'h1234, 16'h0100, 3'b000, 1, 1, 16'h1234);
      vecs[17] = mk(0, 4'b0000, 3'b000, 1, 3'd7, 16'h1234, 16'h0100, 3'b000, 1, 1, 16'h1234);
      vecs[18] = mk(0, 4'b0000, 3'b000, 1, 3'd4, 16'h1234, 16'h0100, 3'b000, 1, 1, 16'h1234);
      vecs[19] = mk(1, 4'b0101, 3'b111, 0, 3'd0, 16'h0000, 16'h0000, 3'b100, 0, 1, 16'h1234);
      vecs[20] = mk(1, 4'b0000, 3'b010, 0, 3'd0, 16'h0000, 16'h0000, 3'b010, 0, 1, 16'h1234);
      vecs[21] = mk(0, 4'b0000, 3'b000, 1, 3'd6, 16'h1234, 16'h0100, 3'b010, 1, 1, 16'h1234);
      vecs[22] = mk(1, 4'b0011, 3'b111, 1, 3'd1, 16'h0200, 16'h0300, 3'b010, 1, 0, 16'h0300);

      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("reset", outs(), pk(3'b000, 1'b0, 1'b0, 16'h0000));
      rst_n = 1'b1;

      for (int i = 0; i < 23; i++) begin
         drive(vecs[i].av, vecs[i].op, vecs[i].fl, vecs[i].bv, vecs[i].cc, vecs[i].tg, vecs[i].pc);
         step($sformatf("vec%0d", i),
              pk(vecs[i].e_flags, vecs[i].e_done, vecs[i].e_taken, vecs[i].e_pc));
      end

      // Hazard: SUB sets Z in the same cycle an EQ branch asks for it.
      drive(1, 4'b0000, 3'b000, 0, 3'd0, 16'h0, 16'h0);
      step("haz_pre", pk(3'b000, 0, 0, 16'h0300));
      drive(1, 4'b0001, 3'b100, 1, 3'd1, 16'h0080, 16'h0020);
      #1;
      check("haz_stall", {31'd0, hazard_stall}, {31'd0, !FWD});
      step("haz_c1", FWD ? pk(3'b100, 1, 1, 16'h0080) : pk(3'b100, 0, 0, 16'h0300));
      idle();
      step("haz_c2", FWD ? pk(3'b100, 0, 1, 16'h0080) : pk(3'b100, 1, 1, 16'h0080));
      step("haz_c3", pk(3'b100, 0, 1, 16'h0080));

      // Stall held for three cycles while a branch result is pending.
      drive(1, 4'b0001, 3'b000, 1, 3'd0, 16'h00a0, 16'h0030);
      step("stl_c1", FWD ? pk(3'b000, 1, 1, 16'h00a0) : pk(3'b000, 0, 1, 16'h0080));
      stall = 1'b1;
      drive(1, 4'b0000, 3'b111, 1, 3'd1, 16'hdead, 16'hbeef);
      for (int i = 0; i < 3; i++)
         step($sformatf("stl_hold%0d", i),
              FWD ? pk(3'b000, 1, 1, 16'h00a0) : pk(3'b000, 0, 1, 16'h0080));
      stall = 1'b0;
      idle();
      step("stl_rel", FWD ? pk(3'b000, 0, 1, 16'h00a0) : pk(3'b000, 1, 1, 16'h00a0));

      // Flush drops a same-cycle branch but still applies the flag update.
      flush = 1'b1;
      drive(1, 4'b0000, 3'b100, 1, 3'd1, 16'h00c0, 16'h0040);
      #1;
      check("fl_nostall", {31'd0, hazard_stall}, 32'd0);
      step("fl_c1", pk(3'b100, 0, 1, 16'h00a0));
      flush = 1'b0;
      idle();
      step("fl_c2", pk(3'b100, 0, 1, 16'h00a0));

      // Flush while a hazard branch is waiting for its flags.
      drive(1, 4'b0001, 3'b000, 1, 3'd0, 16'h00e0, 16'h0050);
      step("flw_c1", FWD ? pk(3'b000, 1, 1, 16'h00e0) : pk(3'b000, 0, 1, 16'h00a0));
      flush = 1'b1;
      idle();
      step("flw_c2", FWD ? pk(3'b000, 0, 1, 16'h00e0) : pk(3'b000, 0, 1, 16'h00a0));
      flush = 1'b0;
      step("flw_c3", FWD ? pk(3'b000, 0, 1, 16'h00e0) : pk(3'b000, 0, 1, 16'h00a0));

      // Stall and flush together: stall wins, br_done pulse is held.
      drive(0, 4'b0000, 3'b000, 1, 3'd1, 16'h0100, 16'h0060);
      step("sf_c1", pk(3'b000, 1, 0, 16'h0060));
      stall = 1'b1; flush = 1'b1;
      idle();
      step("sf_hold", pk(3'b000, 1, 0, 16'h0060));
      stall = 1'b0; flush = 1'b0;
      step("sf_rel", pk(3'b000, 0, 0, 16'h0060));

      // Reset overrides a concurrent stall.
      drive(1, 4'b0000, 3'b111, 0, 3'd0, 16'h0, 16'h0);
      step("rs_pre", pk(3'b111, 0, 0, 16'h0060));
      rst_n = 1'b0; stall = 1'b1;
      step("rs_stall", pk(3'b000, 0, 0, 16'h0000));
      rst_n = 1'b1; stall = 1'b0;
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
